// File: rtl/spi_pkg.sv
// spi_pkg: shared types and default constants for the SPI receive datapath.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } spi_state_t;

   localparam int SPI_DATA_W      = 8;
   localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_input_conditioner.sv
// spi_input_conditioner: synchronizes one raw asynchronous input, optionally
// debounces it (macro SPI_DEBOUNCE_EN) and produces the conditioned level plus
// a one-cycle rising-edge strobe. Never uses the input as a clock.
module spi_input_conditioner
   import spi_pkg::*;
#(
   parameter int   SYNC_STAGES     = SPI_SYNC_STAGES,
   parameter int   DEBOUNCE_CYCLES = 16,
   parameter logic RESET_VAL       = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise
);

   // Reject configurations the synchronizer/debouncer cannot support.
   if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
      $error("spi_input_conditioner: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
   end

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   level_s;
   logic                   prev_r;

   // Metastability chain; reset value chosen so no false edge follows reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_r <= {SYNC_STAGES{RESET_VAL}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      end
   end

`ifdef SPI_DEBOUNCE_EN
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [DB_W-1:0] db_cnt_r;
   logic            db_level_r;

   // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         db_cnt_r   <= DB_W'(0);
         db_level_r <= RESET_VAL;
      end else if (sync_r[SYNC_STAGES-1] == db_level_r) begin
         db_cnt_r   <= DB_W'(0);
      end else if (db_cnt_r == DB_W'(DEBOUNCE_CYCLES - 1)) begin
         db_cnt_r   <= DB_W'(0);
         db_level_r <= sync_r[SYNC_STAGES-1];
      end else begin
         db_cnt_r   <= db_cnt_r + DB_W'(1);
      end
   end

   assign level_s = db_level_r;
`else
   assign level_s = sync_r[SYNC_STAGES-1];
`endif

   // Previous-cycle conditioned level for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_r <= RESET_VAL;
      end else begin
         prev_r <= level_s;
      end
   end

   assign level = level_s;
   assign rise  = level_s & ~prev_r;

endmodule

// File: rtl/spi_rx_controller.sv
// spi_rx_controller: receives MSB-first DATA_W-bit frames from raw button/switch
// SPI signals, all on the system clock. Emits a one-cycle byte_valid strobe per
// completed byte, holds the last byte on display_byte, and flags aborted or
// stalled frames on the sticky frame_err. Optional macro: SPI_DEBOUNCE_EN adds a
// debouncer to the sclk and cs_n paths.
module spi_rx_controller
   import spi_pkg::*;
#(
   parameter int DATA_W          = SPI_DATA_W,
   parameter int SYNC_STAGES     = SPI_SYNC_STAGES,
   parameter int TIMEOUT_CYCLES  = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          sclk_in,
   input  logic                          mosi_in,
   input  logic                          cs_n_in,
   output logic [DATA_W-1:0]             byte_out,
   output logic                          byte_valid,
   output logic [DATA_W-1:0]             display_byte,
   output logic [$clog2(DATA_W+1)-1:0]   bit_count,
   output logic                          busy,
   output logic                          frame_err
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

   // Conditioned inputs
   logic sclk_rise_s, sclk_level_s;
   logic cs_n_level_s, cs_n_rise_s;
   logic [SYNC_STAGES-1:0] mosi_sync_r;
   logic mosi_s;
   logic unused_ok_s;

   // FSM and datapath
   spi_state_t        state_r, state_nxt_s;
   logic [DATA_W-1:0] shift_r, shift_nxt_s, shifted_s;
   logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
   logic [TMO_W-1:0]  tmo_r, tmo_nxt_s;
   logic [DATA_W-1:0] disp_r, disp_nxt_s;
   logic              valid_r, valid_nxt_s;
   logic              err_r, err_nxt_s;
   logic              busy_r;
   logic              cs_low_s, final_edge_s, tmo_hit_s;

   spi_input_conditioner #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b1)
   ) u_sclk_cond (
      .clk   (clk),
      .reset (reset),
      .din   (sclk_in),
      .level (sclk_level_s),
      .rise  (sclk_rise_s)
   );

   spi_input_conditioner #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b1)
   ) u_cs_n_cond (
      .clk   (clk),
      .reset (reset),
      .din   (cs_n_in),
      .level (cs_n_level_s),
      .rise  (cs_n_rise_s)
   );

   // The sclk level and cs_n deassert edge are not needed by the sequencer.
   assign unused_ok_s = &{1'b0, sclk_level_s, cs_n_rise_s};

   // Data line: synchronizer only, sampled when an sclk edge is accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         mosi_sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
         mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi_in};
      end
   end

   assign mosi_s       = mosi_sync_r[SYNC_STAGES-1];
   assign cs_low_s     = ~cs_n_level_s;
   assign shifted_s    = {shift_r[DATA_W-2:0], mosi_s};
   assign final_edge_s = sclk_rise_s && (cnt_r == LAST_BIT);
   assign tmo_hit_s    = (TIMEOUT_CYCLES != 0) && (cnt_r != CNT_W'(0)) &&
                         (tmo_r == TMO_W'(TIMEOUT_CYCLES));

   // State and datapath registers; outputs are all driven from these.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         shift_r <= {DATA_W{1'b0}};
         cnt_r   <= CNT_W'(0);
         tmo_r   <= TMO_W'(0);
         disp_r  <= {DATA_W{1'b0}};
         valid_r <= 1'b0;
         err_r   <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         shift_r <= shift_nxt_s;
         cnt_r   <= cnt_nxt_s;
         tmo_r   <= tmo_nxt_s;
         disp_r  <= disp_nxt_s;
         valid_r <= valid_nxt_s;
         err_r   <= err_nxt_s;
         busy_r  <= (state_nxt_s != IDLE);
      end
   end

   // Next-state logic: a final-bit edge wins over a simultaneous cs_n deassert.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (cs_low_s) state_nxt_s = SHIFT;
            else          state_nxt_s = IDLE;
         end
         SHIFT: begin
            if (final_edge_s)   state_nxt_s = DONE;
            else if (!cs_low_s) state_nxt_s = IDLE;
            else if (tmo_hit_s) state_nxt_s = IDLE;
            else                state_nxt_s = SHIFT;
         end
         DONE: begin
            if (cs_low_s) state_nxt_s = SHIFT;
            else          state_nxt_s = IDLE;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Datapath/output next values: shifting, counting, error and byte hand-off.
   always_comb begin
      shift_nxt_s = shift_r;
      cnt_nxt_s   = cnt_r;
      tmo_nxt_s   = TMO_W'(0);
      disp_nxt_s  = disp_r;
      valid_nxt_s = 1'b0;
      err_nxt_s   = err_r;
      case (state_r)
         IDLE: begin
            cnt_nxt_s = CNT_W'(0);
         end
         SHIFT: begin
            if (final_edge_s) begin
               shift_nxt_s = shifted_s;
               cnt_nxt_s   = FULL_CNT;
               valid_nxt_s = 1'b1;
               disp_nxt_s  = shifted_s;
               err_nxt_s   = 1'b0;
            end else if (!cs_low_s) begin
               shift_nxt_s = {DATA_W{1'b0}};
               cnt_nxt_s   = CNT_W'(0);
               if (cnt_r != CNT_W'(0)) err_nxt_s = 1'b1;
               else                    err_nxt_s = err_r;
            end else if (tmo_hit_s) begin
               shift_nxt_s = {DATA_W{1'b0}};
               cnt_nxt_s   = CNT_W'(0);
               err_nxt_s   = 1'b1;
            end else if (sclk_rise_s) begin
               shift_nxt_s = shifted_s;
               cnt_nxt_s   = cnt_r + CNT_W'(1);
            end else begin
               if ((TIMEOUT_CYCLES != 0) && (cnt_r != CNT_W'(0))) tmo_nxt_s = tmo_r + TMO_W'(1);
               else                                               tmo_nxt_s = TMO_W'(0);
            end
         end
         DONE: begin
            // An edge during DONE is the first bit of the next back-to-back byte.
            if (sclk_rise_s && cs_low_s) begin
               shift_nxt_s = shifted_s;
               cnt_nxt_s   = CNT_W'(1);
            end else begin
               cnt_nxt_s   = CNT_W'(0);
            end
         end
         default: begin
            shift_nxt_s = {DATA_W{1'b0}};
            cnt_nxt_s   = CNT_W'(0);
         end
      endcase
   end

   assign byte_out     = shift_r;
   assign byte_valid   = valid_r;
   assign display_byte = disp_r;
   assign bit_count    = cnt_r;
   assign busy         = busy_r;
   assign frame_err    = err_r;

endmodule

// File: tb/tb_spi_rx_controller.sv
// tb_spi_rx_controller: table-driven and randomized self-checking bench.
// Two instances share stimulus: dut (TIMEOUT_CYCLES=100) and dut_z (timeout off).
module tb_spi_rx_controller;

`ifdef SPI_DEBOUNCE_EN
   localparam int HALF = 28;
`else
   localparam int HALF = 3;
`endif
   localparam int CS_SETUP = 2 * HALF + 4;

   logic       clk, reset, sclk_in, mosi_in, cs_n_in;
   logic [7:0] byte_out, display_byte, byte_out_z, display_byte_z;
   logic       byte_valid, busy, frame_err, byte_valid_z, busy_z, frame_err_z;
   logic [3:0] bit_count, bit_count_z;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [7:0] got_q[$];
   int idle_cnt = 0;
   int pulse_z  = 0;

   spi_rx_controller #(.DATA_W(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(100), .DEBOUNCE_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .sclk_in(sclk_in), .mosi_in(mosi_in), .cs_n_in(cs_n_in),
      .byte_out(byte_out), .byte_valid(byte_valid), .display_byte(display_byte),
      .bit_count(bit_count), .busy(busy), .frame_err(frame_err));

   spi_rx_controller #(.DATA_W(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(0), .DEBOUNCE_CYCLES(16)) dut_z (
      .clk(clk), .reset(reset), .sclk_in(sclk_in), .mosi_in(mosi_in), .cs_n_in(cs_n_in),
      .byte_out(byte_out_z), .byte_valid(byte_valid_z), .display_byte(display_byte_z),
      .bit_count(bit_count_z), .busy(busy_z), .frame_err(frame_err_z));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: sample 2 time units after each rising edge.
   always @(posedge clk) begin
      #2;
      if (byte_valid === 1'b1) got_q.push_back(byte_out);
      if (busy !== 1'b1) idle_cnt++;
      if (byte_valid_z === 1'b1) pulse_z++;
   end

   initial begin
      #(10 * 200000);
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_low();
      @(negedge clk);
      cs_n_in = 1'b0;
      wait_cyc(CS_SETUP);
   endtask

   task automatic cs_high();
      wait_cyc(HALF);
      cs_n_in = 1'b1;
      wait_cyc(CS_SETUP);
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      mosi_in = b;
      wait_cyc(HALF);
      sclk_in = 1'b1;
      wait_cyc(HALF);
      sclk_in = 1'b0;
   endtask

   // Sends nbits of d, MSB (bit 31) first, framed by cs_n.
   task automatic send_frame(input logic [31:0] d, input int nbits);
      cs_low();
      for (int i = 0; i < nbits; i++) send_bit(d[31-i]);
      cs_high();
   endtask

   task automatic check_frame(input string tag, input int q0, input int exp_n,
                              input logic [7:0] exp_b, input logic [7:0] exp_disp,
                              input logic exp_err);
      chk({tag, " pulses"}, 32'(got_q.size() - q0), 32'(exp_n));
      if (exp_n > 0 && got_q.size() > q0) chk({tag, " byte_out"}, 32'(got_q[q0]), 32'(exp_b));
      chk({tag, " display_byte"}, 32'(display_byte), 32'(exp_disp));
      chk({tag, " frame_err"}, 32'(frame_err), 32'(exp_err));
      chk({tag, " bit_count"}, 32'(bit_count), 32'(0));
      chk({tag, " busy"}, 32'(busy), 32'(0));
   endtask

   typedef struct {
      logic [7:0] data;
      int         nbits;
      int         exp_n;
      logic [7:0] exp_disp;
      logic       exp_err;
   } vec_t;

   vec_t tbl [9];

   initial begin
      int q0, s, z0, nfull, part, nb;
      logic [31:0] d;
      logic [7:0] m_disp;
      logic m_err;

      tbl[0] = '{8'hA5, 8, 1, 8'hA5, 1'b0};
      tbl[1] = '{8'hF0, 5, 0, 8'hA5, 1'b1};   // abort after 5 bits
      tbl[2] = '{8'h12, 8, 1, 8'h12, 1'b0};   // good frame clears error
      tbl[3] = '{8'h00, 8, 1, 8'h00, 1'b0};
      tbl[4] = '{8'hFF, 8, 1, 8'hFF, 1'b0};
      tbl[5] = '{8'h00, 0, 0, 8'hFF, 1'b0};   // empty frame, no error
      tbl[6] = '{8'h80, 7, 0, 8'hFF, 1'b1};   // abort one bit short
      tbl[7] = '{8'h00, 0, 0, 8'hFF, 1'b1};   // empty frame keeps sticky error
      tbl[8] = '{8'h01, 8, 1, 8'h01, 1'b0};

      reset = 1'b1; sclk_in = 1'b0; mosi_in = 1'b0; cs_n_in = 1'b1;
      wait_cyc(3);
      chk("reset byte_out", 32'(byte_out), 32'(0));
      chk("reset byte_valid", 32'(byte_valid), 32'(0));
      chk("reset display_byte", 32'(display_byte), 32'(0));
      chk("reset bit_count", 32'(bit_count), 32'(0));
      chk("reset busy", 32'(busy), 32'(0));
      chk("reset frame_err", 32'(frame_err), 32'(0));
      reset = 1'b0;
      wait_cyc(CS_SETUP);
      chk("post-reset no false edge", 32'(got_q.size()), 32'(0));

      // Table-driven single frames
      for (int i = 0; i < 9; i++) begin
         q0 = got_q.size();
         send_frame({tbl[i].data, 24'h0}, tbl[i].nbits);
         check_frame($sformatf("tbl%0d", i), q0, tbl[i].exp_n, tbl[i].data,
                     tbl[i].exp_disp, tbl[i].exp_err);
      end

      // Back-to-back bytes without releasing cs_n
      q0 = got_q.size();
      cs_low();
      s = idle_cnt;
      for (int i = 0; i < 16; i++) send_bit(logic'(16'h3CFF >> (15 - i)));
      chk("b2b busy held", 32'(idle_cnt - s), 32'(0));
      cs_high();
      chk("b2b pulses", 32'(got_q.size() - q0), 32'(2));
      if (got_q.size() >= q0 + 2) begin
         chk("b2b byte0", 32'(got_q[q0]), 32'(8'h3C));
         chk("b2b byte1", 32'(got_q[q0+1]), 32'(8'hFF));
      end
      chk("b2b display_byte", 32'(display_byte), 32'(8'hFF));

`ifndef SPI_DEBOUNCE_EN
      // Latency: byte_valid high in the cycle after edge E0+SYNC_STAGES
      cs_low();
      for (int i = 0; i < 7; i++) send_bit(logic'(8'hB7 >> (7 - i)));
      @(negedge clk);
      mosi_in = 1'b1;
      wait_cyc(HALF);
      sclk_in = 1'b1;
      @(negedge clk);
      chk("lat E0 valid", 32'(byte_valid), 32'(0));
      @(negedge clk);
      chk("lat E0+1 valid", 32'(byte_valid), 32'(0));
      chk("lat E0+1 bit_count", 32'(bit_count), 32'(7));
      @(negedge clk);
      chk("lat E0+2 valid", 32'(byte_valid), 32'(1));
      chk("lat E0+2 byte_out", 32'(byte_out), 32'(8'hB7));
      @(negedge clk);
      chk("lat E0+3 valid", 32'(byte_valid), 32'(0));
      sclk_in = 1'b0;
      cs_high();
      chk("lat display_byte", 32'(display_byte), 32'(8'hB7));
`endif

      // Timeout: 3 bits then stall with cs_n held low
      q0 = got_q.size();
      cs_low();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      wait_cyc(150);
      chk("tmo frame_err", 32'(frame_err), 32'(1));
      chk("tmo bit_count", 32'(bit_count), 32'(0));
      chk("tmo-off frame_err", 32'(frame_err_z), 32'(0));
      chk("tmo-off bit_count", 32'(bit_count_z), 32'(3));
      wait_cyc(900);
      chk("tmo-off frame_err 1000", 32'(frame_err_z), 32'(0));
      chk("tmo-off busy 1000", 32'(busy_z), 32'(1));
      cs_high();
      chk("tmo pulses", 32'(got_q.size() - q0), 32'(0));
      chk("tmo-off abort frame_err", 32'(frame_err_z), 32'(1));

      // Reset mid-frame after 6 bits of 8'hC3
      cs_low();
      for (int i = 0; i < 6; i++) send_bit(logic'(8'hC3 >> (7 - i)));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst byte_out", 32'(byte_out), 32'(0));
      chk("rst byte_valid", 32'(byte_valid), 32'(0));
      chk("rst display_byte", 32'(display_byte), 32'(0));
      chk("rst bit_count", 32'(bit_count), 32'(0));
      chk("rst busy", 32'(busy), 32'(0));
      chk("rst frame_err", 32'(frame_err), 32'(0));
      chk("rst tmo-off frame_err", 32'(frame_err_z), 32'(0));
      cs_n_in = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      wait_cyc(CS_SETUP);
      q0 = got_q.size();
      send_frame({8'h81, 24'h0}, 8);
      check_frame("post-rst", q0, 1, 8'h81, 8'h81, 1'b0);

`ifdef SPI_DEBOUNCE_EN
      // Glitches shorter than the debounce window, then a clean 8'h5A
      q0 = got_q.size();
      cs_low();
      for (int g = 0; g < 4; g++) begin
         @(negedge clk);
         mosi_in = 1'($urandom_range(0, 1));
         sclk_in = 1'b1;
         wait_cyc(5);
         sclk_in = 1'b0;
         wait_cyc(5);
      end
      for (int i = 0; i < 8; i++) send_bit(logic'(8'h5A >> (7 - i)));
      cs_high();
      check_frame("glitch", q0, 1, 8'h5A, 8'h5A, 1'b0);
`endif

      // Randomized frames: 0-2 full bytes plus 0-7 trailing bits
      m_disp = 8'h81;
      m_err  = 1'b0;
      for (int r = 0; r < 16; r++) begin
         d     = $urandom;
         nfull = $urandom_range(0, 2);
         part  = $urandom_range(0, 7);
         nb    = nfull * 8 + part;
         q0    = got_q.size();
         z0    = pulse_z;
         send_frame(d, nb);
         for (int k = 0; k < nfull; k++) m_disp = d[31-8*k -: 8];
         if (part > 0)       m_err = 1'b1;
         else if (nfull > 0) m_err = 1'b0;
         else                m_err = m_err;
         chk($sformatf("rnd%0d pulses", r), 32'(got_q.size() - q0), 32'(nfull));
         for (int k = 0; k < nfull; k++)
            if (got_q.size() > q0 + k)
               chk($sformatf("rnd%0d byte%0d", r, k), 32'(got_q[q0+k]), 32'(d[31-8*k -: 8]));
         chk($sformatf("rnd%0d display_byte", r), 32'(display_byte), 32'(m_disp));
         chk($sformatf("rnd%0d frame_err", r), 32'(frame_err), 32'(m_err));
         chk($sformatf("rnd%0d bit_count", r), 32'(bit_count), 32'(0));
         chk($sformatf("rnd%0d tmo-off pulses", r), 32'(pulse_z - z0), 32'(nfull));
         chk($sformatf("rnd%0d tmo-off display", r), 32'(display_byte_z), 32'(m_disp));
         chk($sformatf("rnd%0d tmo-off frame_err", r), 32'(frame_err_z), 32'(m_err));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/spi_rx_controller.md
Name: spi_rx_controller

Overview:
- Sequences serial byte reception for the switch/button SPI datapath, driving the parser/decoder chain.
- Runs entirely on the board system clock. Raw sclk_in (button), mosi_in (switch) and cs_n_in are synchronized and edge-detected; the inputs are never used as clocks.
- Frames are MSB-first, DATA_W bits each. Each completed byte produces a one-cycle strobe and is held on display_byte for the parser.
- Detects aborted and stalled frames.

Parameters:
- DATA_W, 8, bits per frame.
- SYNC_STAGES, 2, flip-flop synchronizer depth per raw input (minimum 2).
- TIMEOUT_CYCLES, 50_000_000, clk cycles without an accepted sclk edge mid-frame before abort; 0 disables the timeout.
- DEBOUNCE_CYCLES, 16, stable-sample count, used only with SPI_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sclk_in  in  1  raw serial clock from button, asynchronous
- mosi_in  in  1  raw serial data from switch, asynchronous
- cs_n_in  in  1  raw frame select, active-low, asynchronous
- byte_out  out  DATA_W  shift-register contents; valid only while byte_valid is high
- byte_valid  out  1  one-cycle strobe marking a completed frame
- display_byte  out  DATA_W  last completed byte, held; feeds the parser
- bit_count  out  $clog2(DATA_W+1)  bits received in the current frame
- busy  out  1  high in SHIFT or DONE
- frame_err  out  1  sticky abort/timeout flag

Behaviour:
- Reset (synchronous, clk edge with reset=1) forces:
  - state IDLE; shift register, display_byte, bit_count and timeout counter 0; byte_valid 0, busy 0, frame_err 0.
  - Synchronizer and edge-detect registers load 1 for sclk/cs_n and 0 for mosi, so no false edge appears after reset.
  - Reset mid-frame discards the partial byte; display_byte is cleared.
- Input conditioning: each input passes through SYNC_STAGES flops. A rising sclk edge = synchronized level 1 while the previous-cycle level was 0. mosi is taken from its synchronizer output in the cycle the edge is accepted.
- States and transitions:
  - IDLE: bit_count 0. Synchronized cs_n low -> SHIFT. sclk edges are ignored.
  - SHIFT: on each accepted edge, shift = {shift[DATA_W-2:0], mosi} and bit_count increments.
    - The edge that makes bit_count == DATA_W -> DONE.
    - cs_n high with bit_count < DATA_W -> frame_err=1, discard shift register and count, -> IDLE.
    - cs_n high with bit_count == 0 -> IDLE with no error.
    - Timeout counter resets on every accepted edge. When it reaches TIMEOUT_CYCLES with bit_count > 0 -> frame_err=1, -> IDLE.
  - DONE (exactly one cycle):
    - byte_valid=1; byte_out = shift register; display_byte loads the shift register; frame_err clears; bit_count clears.
    - Next state SHIFT if cs_n still low (back-to-back bytes), otherwise IDLE.
- Simultaneous events:
  - Final-bit edge in the same cycle cs_n deasserts -> byte accepted (DONE), no error.
  - Non-final edge in the same cycle cs_n deasserts -> edge ignored, error raised.
  - sclk edges arriving during DONE are not lost: they shift in as bit 1 of the next frame.
- Latency (debounce disabled): let E0 be the clk edge that first captures sclk_in=1 in sync stage 0. The shift happens and state enters DONE at edge E0+SYNC_STAGES; byte_valid is high for the following cycle.
- busy = (state != IDLE).

Optional Feature:
- Macro: SPI_DEBOUNCE_EN.
- Defined: sclk and cs_n each pass a debouncer after the synchronizer. The accepted level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples, adding DEBOUNCE_CYCLES cycles of latency. Edge detection operates on the debounced level. Debouncer counters reset to 0; debounced levels reset to 1.
- Undefined: synchronizer only. DEBOUNCE_CYCLES is unused and no debounce logic is generated.

Decomposition:
- Package spi_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} spi_state_t
  - constant SPI_DATA_W = 8
  - constant SPI_SYNC_STAGES = 2
- One sub-module, spi_input_conditioner: synchronizer, optional debouncer, rising-edge output. Instantiated for sclk_in and cs_n_in; mosi_in uses the synchronizer path only.

Test Plan:
- Reset, then cs_n low and 8 sclk pulses carrying 1010_0101 -> single byte_valid pulse with byte_out=8'hA5; display_byte=8'hA5 thereafter; frame_err=0; bit_count returns to 0.
- cs_n held low, 16 pulses carrying 8'h3C then 8'hFF -> two byte_valid pulses (3C, then FF); display_byte ends at 8'hFF; no return to IDLE between bytes.
- Abort: cs_n low, 5 pulses, cs_n high -> frame_err=1, no byte_valid, display_byte unchanged. A following good frame 8'h12 -> byte_valid, frame_err=0.
- Timeout with TIMEOUT_CYCLES=100: 3 pulses then idle 100 cycles -> frame_err=1, state IDLE, bit_count=0. Repeat with TIMEOUT_CYCLES=0 -> no error after 1000 idle cycles.
- Reset asserted after bit 6 of 8'hC3 -> all outputs 0 next cycle. A subsequent full frame 8'h81 -> byte_valid with 8'h81.
- With SPI_DEBOUNCE_EN and DEBOUNCE_CYCLES=16: glitchy sclk (pulses shorter than 16 cycles) plus 8 clean pulses carrying 8'h5A -> exactly one byte_valid with 8'h5A. Without the macro, measure byte_valid at edge E0+SYNC_STAGES.
